// File: rtl/regfile_onehot_32x32_if.sv
// Bus bundle for the 32x32 register file: one-hot write port and two read ports.
interface regfile_onehot_32x32_if #(
   parameter int unsigned WIDTH = 32
);
   logic              wr_en;
   logic [0:31]       wr_sel;
   logic [WIDTH-1:0]  wr_data;
   logic [0:4]        rd_addr_a;
   logic [0:4]        rd_addr_b;
   logic [WIDTH-1:0]  rd_data_a;
   logic [WIDTH-1:0]  rd_data_b;
   logic              sel_err;
   logic [15:0]       wr_count;

   // Datapath side drives write/read requests and consumes read data and status.
   modport master (
      output wr_en, wr_sel, wr_data, rd_addr_a, rd_addr_b,
      input  rd_data_a, rd_data_b, sel_err, wr_count
   );

   // Register file side.
   modport slave (
      input  wr_en, wr_sel, wr_data, rd_addr_a, rd_addr_b,
      output rd_data_a, rd_data_b, sel_err, wr_count
   );
endinterface

// File: rtl/regfile_onehot_32x32.sv
// 32 x WIDTH register file written through a one-hot row select, with two
// combinational read ports, optional write-through bypass, r0 tied to zero,
// select-error flag and a committed-write counter.
module regfile_onehot_32x32 #(
   parameter int unsigned WIDTH      = 32,
   parameter bit          BYPASS     = 1'b1,
   parameter bit          ERR_STICKY = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   regfile_onehot_32x32_if.slave   bus
);

   logic [WIDTH-1:0] regs_q [32];
   logic [WIDTH-1:0] regs_d [32];
   logic             sel_err_q, sel_err_d;
   logic [15:0]      wr_count_q, wr_count_d;

   logic             sel_onehot;
   logic             commit;
   logic             sel_bad;
   logic [4:0]       wr_idx;

   // Decode the one-hot select into an index and qualify the write.
   always_comb begin
      wr_idx = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (bus.wr_sel[i]) wr_idx = 5'(i);
      end
      sel_onehot = $onehot(bus.wr_sel);
      commit     = rst_n && bus.wr_en && sel_onehot && (wr_idx != 5'd0);
      sel_bad    = bus.wr_en && !sel_onehot;
   end

   // Next-state for the register array, error flag and write counter.
   always_comb begin
      regs_d     = regs_q;
      wr_count_d = wr_count_q;
      sel_err_d  = ERR_STICKY ? sel_err_q : 1'b0;
      if (commit) begin
         regs_d[wr_idx] = bus.wr_data;
         wr_count_d     = wr_count_q + 16'd1;
      end
      if (sel_bad) sel_err_d = 1'b1;
   end

   // State registers with synchronous active-low reset; reset wins over writes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
         sel_err_q  <= 1'b0;
         wr_count_q <= '0;
      end else begin
         regs_q     <= regs_d;
         sel_err_q  <= sel_err_d;
         wr_count_q <= wr_count_d;
      end
   end

   // Combinational read ports; r0 reads zero, bypass uses the commit qualifier.
   always_comb begin
      if (bus.rd_addr_a == 5'd0)
         bus.rd_data_a = '0;
      else if (BYPASS && commit && (bus.rd_addr_a == wr_idx))
         bus.rd_data_a = bus.wr_data;
      else
         bus.rd_data_a = regs_q[bus.rd_addr_a];

      if (bus.rd_addr_b == 5'd0)
         bus.rd_data_b = '0;
      else if (BYPASS && commit && (bus.rd_addr_b == wr_idx))
         bus.rd_data_b = bus.wr_data;
      else
         bus.rd_data_b = regs_q[bus.rd_addr_b];
   end

   assign bus.sel_err  = sel_err_q;
   assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_onehot_32x32.sv
// Self-checking bench: two instances (bypass+sticky, no-bypass+pulse) driven
// identically and compared against a behavioural array model.
module tb_regfile_onehot_32x32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [0:31] wr_sel;
   logic [31:0] wr_data;
   logic [0:4]  ra, rb;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model
   logic [31:0] mreg [32];
   int          mcnt;
   bit          merr_s, merr_p;

   always #5 clk = ~clk;

   regfile_onehot_32x32_if #(.WIDTH(32)) bus1 ();
   regfile_onehot_32x32_if #(.WIDTH(32)) bus0 ();

   assign bus1.wr_en     = wr_en;
   assign bus1.wr_sel    = wr_sel;
   assign bus1.wr_data   = wr_data;
   assign bus1.rd_addr_a = ra;
   assign bus1.rd_addr_b = rb;
   assign bus0.wr_en     = wr_en;
   assign bus0.wr_sel    = wr_sel;
   assign bus0.wr_data   = wr_data;
   assign bus0.rd_addr_a = ra;
   assign bus0.rd_addr_b = rb;

   regfile_onehot_32x32 #(.WIDTH(32), .BYPASS(1'b1), .ERR_STICKY(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
   regfile_onehot_32x32 #(.WIDTH(32), .BYPASS(1'b0), .ERR_STICKY(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

   typedef struct {
      bit          rst_n;
      bit          en;
      logic [0:31] sel;
      logic [31:0] data;
      logic [4:0]  addr;
      logic [31:0] exp_byp;
      logic [31:0] exp_nobyp;
      bit          exp_err_s;
      bit          exp_err_p;
      int          exp_cnt;
   } vec_t;

   vec_t vecs [14];

   function automatic logic [0:31] bitsel(input int i);
      logic [0:31] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int sel_index();
      int idx = -1;
      for (int i = 0; i < 32; i++) if (wr_sel[i]) idx = i;
      return idx;
   endfunction

   function automatic bit commits_now();
      return rst_n && wr_en && ($countones(wr_sel) == 1) && (sel_index() != 0);
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit byp);
      if (addr == 0) return 32'h0;
      if (byp && commits_now() && (sel_index() == int'(addr))) return wr_data;
      return mreg[addr];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit bad;
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
         mcnt   = 0;
         merr_s = 1'b0;
         merr_p = 1'b0;
      end else begin
         bad = wr_en && ($countones(wr_sel) != 1);
         if (commits_now()) begin
            mreg[sel_index()] = wr_data;
            mcnt = (mcnt + 1) % 65536;
         end
         merr_s = merr_s | bad;
         merr_p = bad;
      end
   endtask

   task automatic pre_check();
      chk("rd_a_byp",   bus1.rd_data_a, exp_read(ra, 1'b1));
      chk("rd_b_byp",   bus1.rd_data_b, exp_read(rb, 1'b1));
      chk("rd_a_nobyp", bus0.rd_data_a, exp_read(ra, 1'b0));
      chk("rd_b_nobyp", bus0.rd_data_b, exp_read(rb, 1'b0));
   endtask

   task automatic post_check();
      chk("sel_err_sticky", {31'h0, bus1.sel_err}, {31'h0, merr_s});
      chk("sel_err_pulse",  {31'h0, bus0.sel_err}, {31'h0, merr_p});
      chk("wr_count_1",     {16'h0, bus1.wr_count}, 32'(mcnt));
      chk("wr_count_0",     {16'h0, bus0.wr_count}, 32'(mcnt));
   endtask

   // one clock: inputs already applied; reads checked at negedge, state after posedge
   task automatic cycle();
      @(negedge clk);
      pre_check();
      @(posedge clk);
      model_edge();
      #1;
      post_check();
   endtask

   task automatic drive(input bit r, input bit e, input logic [0:31] s,
                        input logic [31:0] d, input logic [4:0] a, input logic [4:0] b);
      rst_n = r; wr_en = e; wr_sel = s; wr_data = d; ra = a; rb = b;
   endtask

   task automatic static_reads(input string tag);
      wr_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         ra = 5'(i);
         rb = 5'(31 - i);
         #1;
         chk({tag, "_a1"}, bus1.rd_data_a, mreg[i]);
         chk({tag, "_b1"}, bus1.rd_data_b, mreg[31 - i]);
         chk({tag, "_a0"}, bus0.rd_data_a, mreg[i]);
         chk({tag, "_b0"}, bus0.rd_data_b, mreg[31 - i]);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a, b, k;
      for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
      mcnt = 0; merr_s = 1'b0; merr_p = 1'b0;

      // hand-computed table, applied right after reset
      vecs[0]  = '{1, 1, bitsel(5),             32'hDEADBEEF, 5, 32'hDEADBEEF, 32'h0,        0, 0, 1};
      vecs[1]  = '{1, 0, bitsel(5),             32'h0,        5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1};
      vecs[2]  = '{1, 1, bitsel(0),             32'hFFFFFFFF, 0, 32'h0,        32'h0,        0, 0, 1};
      vecs[3]  = '{1, 0, bitsel(3) | bitsel(7), 32'h1234,     3, 32'h0,        32'h0,        0, 0, 1};
      vecs[4]  = '{1, 0, 32'h0,                 32'h0,        5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1};
      vecs[5]  = '{1, 1, bitsel(9),             32'h11,       9, 32'h11,       32'h0,        0, 0, 2};
      vecs[6]  = '{1, 1, bitsel(9),             32'h22,       9, 32'h22,       32'h11,       0, 0, 3};
      vecs[7]  = '{1, 1, bitsel(3) | bitsel(7), 32'h55,       3, 32'h0,        32'h0,        1, 1, 3};
      vecs[8]  = '{1, 0, 32'h0,                 32'h0,        9, 32'h22,       32'h22,       1, 0, 3};
      vecs[9]  = '{1, 1, 32'h0,                 32'h66,       7, 32'h0,        32'h0,        1, 1, 3};
      vecs[10] = '{1, 0, 32'h0,                 32'h0,        7, 32'h0,        32'h0,        1, 0, 3};
      vecs[11] = '{1, 1, bitsel(4),             32'h77,       4, 32'h77,       32'h0,        1, 0, 4};
      vecs[12] = '{0, 1, bitsel(4),             32'h88,       4, 32'h77,       32'h77,       0, 0, 0};
      vecs[13] = '{1, 0, 32'h0,                 32'h0,        4, 32'h0,        32'h0,        0, 0, 0};

      drive(0, 0, '0, '0, 0, 0);
      @(posedge clk); model_edge(); #1;
      post_check();

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].en, vecs[i].sel, vecs[i].data, vecs[i].addr, vecs[i].addr);
         @(negedge clk);
         pre_check();
         chk("tab_rd_a_byp",   bus1.rd_data_a, vecs[i].exp_byp);
         chk("tab_rd_b_byp",   bus1.rd_data_b, vecs[i].exp_byp);
         chk("tab_rd_a_nobyp", bus0.rd_data_a, vecs[i].exp_nobyp);
         @(posedge clk);
         model_edge();
         #1;
         post_check();
         chk("tab_err_s", {31'h0, bus1.sel_err}, {31'h0, vecs[i].exp_err_s});
         chk("tab_err_p", {31'h0, bus0.sel_err}, {31'h0, vecs[i].exp_err_p});
         chk("tab_cnt",   {16'h0, bus1.wr_count}, 32'(vecs[i].exp_cnt));
      end

      // write all 31 registers with i*0x01010101, then read back via both ports
      for (int i = 1; i < 32; i++) begin
         drive(1, 1, bitsel(i), 32'(i) * 32'h01010101, 5'(i), 5'(i));
         cycle();
      end
      chk("fill_cnt", {16'h0, bus1.wr_count}, 32'd31);
      static_reads("fill");
      chk("fill_r17", bus1.rd_data_a, mreg[31]);
      ra = 5'd17; #1;
      chk("fill_r17_lit", bus1.rd_data_a, 32'h11111111);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         k = $urandom_range(0, 99);
         a = $urandom_range(0, 31);
         b = (a + 1 + $urandom_range(0, 30)) % 32;
         rst_n   = ($urandom_range(0, 59) != 0);
         wr_en   = ($urandom_range(0, 3) != 0);
         wr_data = $urandom;
         if (k < 60)      wr_sel = bitsel(a);
         else if (k < 70) wr_sel = '0;
         else if (k < 85) wr_sel = bitsel(a) | bitsel(b);
         else             wr_sel = $urandom;
         ra = ($urandom_range(0, 2) == 0) ? 5'(a) : 5'($urandom_range(0, 31));
         rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
         cycle();
      end

      // reset after random writes: reads hold old contents until the edge
      for (int i = 1; i < 32; i++) begin
         drive(1, 1, bitsel(i), $urandom | 32'h1, 5'(i), 5'(i));
         cycle();
      end
      drive(0, 1, bitsel(12), 32'hCAFE0001, 5'd12, 5'd13);
      cycle();
      chk("rst_cnt", {16'h0, bus1.wr_count}, 32'd0);
      chk("rst_err", {31'h0, bus1.sel_err}, 32'd0);
      rst_n = 1'b1;
      static_reads("rst");

      // error pulse vs sticky over several idle cycles
      drive(1, 1, bitsel(2) | bitsel(30), 32'h5A5A5A5A, 5'd2, 5'd30);
      cycle();
      drive(1, 0, bitsel(2) | bitsel(30), 32'h0, 5'd2, 5'd30);
      for (int i = 0; i < 3; i++) cycle();
      chk("err_held", {31'h0, bus1.sel_err}, 32'd1);
      chk("err_pulse_gone", {31'h0, bus0.sel_err}, 32'd0);

      // counter wrap
      drive(0, 0, '0, '0, 0, 0);
      cycle();
      for (int n = 0; n < 65535; n++) begin
         drive(1, 1, bitsel(1 + (n % 31)), 32'(n), 5'(1 + (n % 31)), 5'(1 + ((n + 5) % 31)));
         cycle();
      end
      chk("wrap_ffff", {16'h0, bus1.wr_count}, 32'h0000FFFF);
      drive(1, 1, bitsel(20), 32'hABCD, 5'd20, 5'd0);
      cycle();
      chk("wrap_zero", {16'h0, bus1.wr_count}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
